multi_channel_serializer: RTL

Successor to the single-channel wide-to-narrow serializer. It arbitrates round-robin among NUM_CHANNELS wide valid/ready inputs and sends each accepted word over one narrow valid/ready link. Each word goes out as one header flit carrying the source channel ID, then the payload flits, most-significant slice first. The block sits between the per-channel hub FIFOs and the shared physical narrow FIFO or link; a matching demuxing deserializer sits at the far end.

---
 rtl/multi_channel_serializer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multi_channel_serializer.sv
// -----------------------------------------------------------------------------
// multi_channel_serializer
//
// Round-robin arbitrates among NUM_CHANNELS wide valid/ready inputs and sends
// each accepted word over one narrow valid/ready link. A word goes out as one
// header flit carrying the source channel ID (zero-extended), followed by
// FLITS payload flits, most-significant slice first. On the last-flit
// handshake the arbiter is evaluated in the same cycle, so back-to-back words
// need FLITS+1 link cycles each with no bubble.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous reset, active low (0 = in reset)
//   wide_fifo_data      per-channel words, channel c at [c*W +: W]
//   wide_fifo_valid     per-channel word available
//   wide_fifo_ready     one-hot accept strobe (combinational)
//   narrow_fifo_valid   flit valid
//   narrow_fifo_ready   downstream accepts a flit
//   narrow_fifo_data    flit payload / header ID
//   narrow_fifo_header  high on header flits
//   narrow_fifo_last    high on the final payload flit of a word
//   busy                high while a word is being sent
//
// HUB_FIFO_WIDTH must be an exact multiple of HUB_FIFO_PHYSICAL_WIDTH, and the
// flit must be wide enough to carry a channel ID.
// -----------------------------------------------------------------------------
module multi_channel_serializer #(
  parameter int NUM_CHANNELS            = 4,
  parameter int HUB_FIFO_WIDTH          = 32,
  parameter int HUB_FIFO_PHYSICAL_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS*HUB_FIFO_WIDTH-1:0] wide_fifo_data,
  input  logic [NUM_CHANNELS-1:0]                wide_fifo_valid,
  output logic [NUM_CHANNELS-1:0]                wide_fifo_ready,
  output logic                                   narrow_fifo_valid,
  input  logic                                   narrow_fifo_ready,
  output logic [HUB_FIFO_PHYSICAL_WIDTH-1:0]     narrow_fifo_data,
  output logic                                   narrow_fifo_header,
  output logic                                   narrow_fifo_last,
  output logic                                   busy
);

  localparam int FLITS       = HUB_FIFO_WIDTH / HUB_FIFO_PHYSICAL_WIDTH;
  localparam int CH_ID_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_WIDTH   = (FLITS > 1) ? $clog2(FLITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [HUB_FIFO_WIDTH-1:0]   shift_reg;
  logic [CNT_WIDTH-1:0]        flit_cnt;
  logic [CH_ID_WIDTH-1:0]      ch_id;
  logic [CH_ID_WIDTH-1:0]      last_grant;

  logic                        grant_valid;
  logic [CH_ID_WIDTH-1:0]      grant_idx;
  logic [HUB_FIFO_WIDTH-1:0]   grant_word;
  logic                        last_flit;
  logic                        accept_window;
  logic                        accept;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after last_grant+1. Scanning
  // offsets from the far end down lets the nearest requester overwrite the
  // result last, so it wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    int                     cand;
    logic [CH_ID_WIDTH-1:0] cand_idx;
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    cand        = 0;
    cand_idx    = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      cand     = (int'(last_grant) + 1 + i) % NUM_CHANNELS;
      cand_idx = CH_ID_WIDTH'(cand);
      if (wide_fifo_valid[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Word of the winning channel.
  always_comb begin
    grant_word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant_idx == CH_ID_WIDTH'(c)) begin
        grant_word = wide_fifo_data[c*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Link outputs are decoded from registered state only, so they hold stable
  // for free while the link stalls.
  // ---------------------------------------------------------------------------
  assign last_flit          = (state == PAYLOAD) && (flit_cnt == CNT_WIDTH'(FLITS - 1));
  assign narrow_fifo_valid  = (state != IDLE);
  assign busy               = (state != IDLE);
  assign narrow_fifo_header = (state == HEADER);
  assign narrow_fifo_last   = last_flit;

  always_comb begin
    narrow_fifo_data = '0;
    unique case (state)
      HEADER:  narrow_fifo_data = HUB_FIFO_PHYSICAL_WIDTH'(ch_id);
      PAYLOAD: narrow_fifo_data = shift_reg[HUB_FIFO_WIDTH-1 -: HUB_FIFO_PHYSICAL_WIDTH];
      default: narrow_fifo_data = '0;
    endcase
  end

  // A new word may be taken when idle, or in the very cycle the last flit of
  // the current word handshakes. Gating with reset keeps a word from being
  // consumed in a cycle whose state update is about to be discarded.
  assign accept_window   = reset && ((state == IDLE) || (last_flit && narrow_fifo_ready));
  assign accept          = accept_window && grant_valid;
  assign wide_fifo_ready = accept ? (NUM_CHANNELS'(1) << grant_idx) : '0;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = HEADER;
      end
      HEADER: begin
        if (narrow_fifo_ready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (last_flit && narrow_fifo_ready) state_next = accept ? HEADER : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, flit counter, captured ID, round-robin pointer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: these are a handful of flops, not a memory array, so resetting
      // them is cheap and guarantees no stale payload survives a reset.
      shift_reg  <= '0;
      flit_cnt   <= '0;
      ch_id      <= '0;
      last_grant <= CH_ID_WIDTH'(NUM_CHANNELS - 1);  // channel 0 is next
    end else if (accept) begin
      shift_reg  <= grant_word;
      flit_cnt   <= '0;
      ch_id      <= grant_idx;
      last_grant <= grant_idx;
    end else if (state == HEADER && narrow_fifo_ready) begin
      flit_cnt   <= '0;
    end else if (state == PAYLOAD && narrow_fifo_ready) begin
      shift_reg  <= shift_reg << HUB_FIFO_PHYSICAL_WIDTH;
      flit_cnt   <= flit_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
